sd_card_detect_debounce: RTL and testbench

Debounces the already-synchronized SD card-detect level and turns it into a stable `card_present` flag, one-cycle insert/remove event pulses, and sticky interrupt status bits with software clear. Sits directly downstream of the card-detect synchronizer in the SDHC host, in the host `clk` domain, and feeds the SDHC register/interrupt block.

---
 rtl/sd_card_detect_debounce_if.sv | 21 ++
 rtl/sd_card_detect_debounce.sv | 87 ++++++++
 tb/tb_sd_card_detect_debounce.sv | 123 ++++++++++++
 3 files changed

// File: rtl/sd_card_detect_debounce_if.sv
// sd_card_detect_debounce_if: card-detect debouncer signal bundle
// master drives cd_sync/clr strobes and observes status; slave is the debouncer.
interface sd_card_detect_debounce_if;
    logic cd_sync;
    logic clr_insert;
    logic clr_remove;
    logic card_present;
    logic insert_evt;
    logic remove_evt;
    logic insert_pending;
    logic remove_pending;
    logic irq;
    modport master (
        output cd_sync, clr_insert, clr_remove,
        input  card_present, insert_evt, remove_evt, insert_pending, remove_pending, irq
    );
    modport slave (
        input  cd_sync, clr_insert, clr_remove,
        output card_present, insert_evt, remove_evt, insert_pending, remove_pending, irq
    );
endinterface

// File: rtl/sd_card_detect_debounce.sv
// sd_card_detect_debounce: debounces synchronized card-detect into presence, event pulses and sticky irq status
// Ports: clk, rst (sync active-high), bus (slave modport: cd_sync, clr_insert/clr_remove in;
// card_present, insert_evt, remove_evt, insert_pending, remove_pending, irq out).
module sd_card_detect_debounce #(
    parameter int DEBOUNCE_CYCLES = 65536,
    parameter bit CD_ACTIVE_LOW   = 1'b1,
    parameter int CNT_W           = $clog2(DEBOUNCE_CYCLES + 1)
) (
    input logic                       clk,
    input logic                       rst,
    sd_card_detect_debounce_if.slave  bus
);
    typedef enum logic [1:0] {ABSENT, INS_WAIT, PRESENT, REM_WAIT} state_t;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
    state_t            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              present_q, present_d;
    logic              ins_evt_q, ins_evt_d;
    logic              rem_evt_q, rem_evt_d;
    logic              ins_pend_q, ins_pend_d;
    logic              rem_pend_q, rem_pend_d;
    logic              irq_q, irq_d;
    logic              cd;
    assign cd = bus.cd_sync ^ CD_ACTIVE_LOW;
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        present_d = present_q;
        ins_evt_d = 1'b0;
        rem_evt_d = 1'b0;
        case (state_q)
            ABSENT: if (cd) begin
                state_d = INS_WAIT;
                cnt_d   = '0;
            end
            INS_WAIT: if (!cd) state_d = ABSENT;
            else if (cnt_q == LAST) begin
                state_d   = PRESENT;
                present_d = 1'b1;
                ins_evt_d = 1'b1;
            end else cnt_d = cnt_q + 1'b1;
            PRESENT: if (!cd) begin
                state_d = REM_WAIT;
                cnt_d   = '0;
            end
            REM_WAIT: if (cd) state_d = PRESENT;
            else if (cnt_q == LAST) begin
                state_d   = ABSENT;
                present_d = 1'b0;
                rem_evt_d = 1'b1;
            end else cnt_d = cnt_q + 1'b1;
            default: state_d = ABSENT;
        endcase
        // Set wins over clear both at the setting edge and while the event pulse is visible,
        // so a clear issued in response to the pulse cannot swallow the new status.
        ins_pend_d = ins_evt_d | ins_evt_q | (ins_pend_q & ~bus.clr_insert);
        rem_pend_d = rem_evt_d | rem_evt_q | (rem_pend_q & ~bus.clr_remove);
        irq_d      = ins_pend_q | rem_pend_q;
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ABSENT;
            cnt_q      <= '0;
            present_q  <= 1'b0;
            ins_evt_q  <= 1'b0;
            rem_evt_q  <= 1'b0;
            ins_pend_q <= 1'b0;
            rem_pend_q <= 1'b0;
            irq_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            present_q  <= present_d;
            ins_evt_q  <= ins_evt_d;
            rem_evt_q  <= rem_evt_d;
            ins_pend_q <= ins_pend_d;
            rem_pend_q <= rem_pend_d;
            irq_q      <= irq_d;
        end
    end
    assign bus.card_present   = present_q;
    assign bus.insert_evt     = ins_evt_q;
    assign bus.remove_evt     = rem_evt_q;
    assign bus.insert_pending = ins_pend_q;
    assign bus.remove_pending = rem_pend_q;
    assign bus.irq            = irq_q;
endmodule

// File: tb/tb_sd_card_detect_debounce.sv
// tb_sd_card_detect_debounce: directed checks of debounce timing, events, pending bits and irq
module tb_sd_card_detect_debounce;
    logic clk = 1'b0;
    logic rst;
    int   errors = 0;
    int   checks = 0;
    always #5 clk = ~clk;
    sd_card_detect_debounce_if ifa ();
    sd_card_detect_debounce_if ifb ();
    sd_card_detect_debounce #(.DEBOUNCE_CYCLES(4), .CD_ACTIVE_LOW(1'b1)) dut_a (.clk(clk), .rst(rst), .bus(ifa));
    sd_card_detect_debounce #(.DEBOUNCE_CYCLES(1), .CD_ACTIVE_LOW(1'b0)) dut_b (.clk(clk), .rst(rst), .bus(ifb));
    // {card_present, insert_evt, remove_evt, insert_pending, remove_pending, irq}
    logic [5:0] a_o, b_o;
    assign a_o = {ifa.card_present, ifa.insert_evt, ifa.remove_evt, ifa.insert_pending, ifa.remove_pending, ifa.irq};
    assign b_o = {ifb.card_present, ifb.insert_evt, ifb.remove_evt, ifb.insert_pending, ifb.remove_pending, ifb.irq};
    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask
    task automatic test_reset;
        rst = 1'b1;
        ifa.cd_sync = 1'b1; ifa.clr_insert = 1'b0; ifa.clr_remove = 1'b0;
        ifb.cd_sync = 1'b0; ifb.clr_insert = 1'b0; ifb.clr_remove = 1'b0;
        tick(2);
        checks++; if (a_o !== 6'b000000) begin errors++; $display("FAIL reset_a: got %b want 000000", a_o); end
        checks++; if (b_o !== 6'b000000) begin errors++; $display("FAIL reset_b: got %b want 000000", b_o); end
        rst = 1'b0;
        tick(3);
        checks++; if (a_o !== 6'b000000) begin errors++; $display("FAIL idle_a: got %b want 000000", a_o); end
    endtask
    task automatic test_clean_insert;
        ifa.cd_sync = 1'b0;
        tick(1);
        checks++; if (a_o !== 6'b000000) begin errors++; $display("FAIL ins_e0: got %b want 000000", a_o); end
        tick(3);
        checks++; if (a_o !== 6'b000000) begin errors++; $display("FAIL ins_e3: got %b want 000000", a_o); end
        tick(1);
        checks++; if (a_o !== 6'b110100) begin errors++; $display("FAIL ins_e4: got %b want 110100", a_o); end
        tick(1);
        checks++; if (a_o !== 6'b100101) begin errors++; $display("FAIL ins_e5: got %b want 100101", a_o); end
    endtask
    task automatic test_full_cycle;
        ifa.cd_sync = 1'b1;
        tick(4);
        checks++; if (a_o !== 6'b100101) begin errors++; $display("FAIL rem_e3: got %b want 100101", a_o); end
        tick(1);
        checks++; if (a_o !== 6'b001111) begin errors++; $display("FAIL rem_e4: got %b want 001111", a_o); end
        tick(1);
        checks++; if (a_o !== 6'b000111) begin errors++; $display("FAIL rem_e5: got %b want 000111", a_o); end
    endtask
    task automatic test_clear;
        ifa.clr_insert = 1'b1; tick(1); ifa.clr_insert = 1'b0;
        checks++; if (a_o !== 6'b000011) begin errors++; $display("FAIL clr_ins: got %b want 000011", a_o); end
        tick(1);
        checks++; if (a_o !== 6'b000011) begin errors++; $display("FAIL clr_ins_irq: got %b want 000011", a_o); end
        ifa.clr_insert = 1'b1; tick(1); ifa.clr_insert = 1'b0;
        checks++; if (a_o !== 6'b000011) begin errors++; $display("FAIL clr_noop: got %b want 000011", a_o); end
        ifa.clr_remove = 1'b1; tick(1); ifa.clr_remove = 1'b0;
        checks++; if (a_o !== 6'b000001) begin errors++; $display("FAIL clr_rem: got %b want 000001", a_o); end
        tick(1);
        checks++; if (a_o !== 6'b000000) begin errors++; $display("FAIL irq_drop: got %b want 000000", a_o); end
    endtask
    task automatic test_bounce;
        ifa.cd_sync = 1'b0; tick(3);
        checks++; if (a_o !== 6'b000000) begin errors++; $display("FAIL bounce_burst: got %b want 000000", a_o); end
        ifa.cd_sync = 1'b1; tick(1);
        checks++; if (a_o !== 6'b000000) begin errors++; $display("FAIL bounce_glitch: got %b want 000000", a_o); end
        ifa.cd_sync = 1'b0; tick(4);
        checks++; if (a_o !== 6'b000000) begin errors++; $display("FAIL bounce_e3: got %b want 000000", a_o); end
        ifa.clr_insert = 1'b1; tick(1);
        checks++; if (a_o !== 6'b110100) begin errors++; $display("FAIL bounce_e4: got %b want 110100", a_o); end
        tick(1); ifa.clr_insert = 1'b0;
        checks++; if (a_o !== 6'b100101) begin errors++; $display("FAIL set_wins: got %b want 100101", a_o); end
        ifa.clr_insert = 1'b1; tick(1); ifa.clr_insert = 1'b0;
        checks++; if (a_o !== 6'b100001) begin errors++; $display("FAIL clr_after: got %b want 100001", a_o); end
        tick(1);
        checks++; if (a_o !== 6'b100000) begin errors++; $display("FAIL clr_after_irq: got %b want 100000", a_o); end
    endtask
    task automatic test_reset_mid;
        ifa.cd_sync = 1'b1; tick(4);
        checks++; if (a_o !== 6'b100000) begin errors++; $display("FAIL rm_rem_e3: got %b want 100000", a_o); end
        tick(1);
        checks++; if (a_o !== 6'b001010) begin errors++; $display("FAIL rm_rem_e4: got %b want 001010", a_o); end
        ifa.cd_sync = 1'b0; tick(3);
        checks++; if (a_o !== 6'b000011) begin errors++; $display("FAIL rm_wait: got %b want 000011", a_o); end
        rst = 1'b1; tick(1);
        checks++; if (a_o !== 6'b000000) begin errors++; $display("FAIL rm_rst: got %b want 000000", a_o); end
        rst = 1'b0; tick(1);
        checks++; if (a_o !== 6'b000000) begin errors++; $display("FAIL rm_e0: got %b want 000000", a_o); end
        tick(3);
        checks++; if (a_o !== 6'b000000) begin errors++; $display("FAIL rm_e3: got %b want 000000", a_o); end
        tick(1);
        checks++; if (a_o !== 6'b110100) begin errors++; $display("FAIL rm_e4: got %b want 110100", a_o); end
    endtask
    task automatic test_polarity_min;
        checks++; if (b_o !== 6'b000000) begin errors++; $display("FAIL b_idle: got %b want 000000", b_o); end
        ifb.cd_sync = 1'b1; tick(1);
        checks++; if (b_o !== 6'b000000) begin errors++; $display("FAIL b_single_e0: got %b want 000000", b_o); end
        ifb.cd_sync = 1'b0; tick(1);
        checks++; if (b_o !== 6'b000000) begin errors++; $display("FAIL b_single_e1: got %b want 000000", b_o); end
        tick(1);
        checks++; if (b_o !== 6'b000000) begin errors++; $display("FAIL b_single_e2: got %b want 000000", b_o); end
        ifb.cd_sync = 1'b1; tick(1);
        checks++; if (b_o !== 6'b000000) begin errors++; $display("FAIL b_e0: got %b want 000000", b_o); end
        tick(1);
        checks++; if (b_o !== 6'b110100) begin errors++; $display("FAIL b_e1: got %b want 110100", b_o); end
        tick(1);
        checks++; if (b_o !== 6'b100101) begin errors++; $display("FAIL b_e2: got %b want 100101", b_o); end
    endtask
    initial begin
        test_reset();
        test_clean_insert();
        test_full_cycle();
        test_clear();
        test_bounce();
        test_reset_mid();
        test_polarity_min();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
